// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive frame stage.
// In-band status helpers are used only when RGMII_RX_INBAND_STATUS_EN is defined.
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0] SFD_BYTE        = 8'hD5;
    localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE      = 4'hD;
    localparam logic [3:0] FALSE_CARRIER   = 4'hE;

    localparam int IB_LINK_BIT   = 0;
    localparam int IB_SPEED_LSB  = 1;
    localparam int IB_DUPLEX_BIT = 3;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // The reserved code 2'b11 is passed through unchanged.
    function automatic logic [1:0] inband_speed(input logic [3:0] nib);
        logic [1:0] code;
        code = nib[IB_SPEED_LSB +: 2];
        case (code)
            2'b00:   return SPEED_10;
            2'b01:   return SPEED_100;
            2'b10:   return SPEED_1000;
            default: return code;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_rx_nibble_asm.sv
// Byte assembly from captured RGMII nibbles: whole byte per cycle at 1000,
// low-then-high nibble pairs from the rising sample at 10/100.
module rgmii_rx_nibble_asm
    import rgmii_pkg::*;
(
    input  logic       mac_rxc,
    input  logic       rst_n,
    input  logic       mode_1g,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] rxd_rise,
    input  logic [3:0] rxd_fall,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       odd_nibble
);

    logic       phase_q;
    logic [3:0] low_q;

    always_ff @(posedge mac_rxc or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            low_q   <= 4'h0;
        end else if (clr) begin
            phase_q <= 1'b0;
        end else if (en && !mode_1g) begin
            if (!phase_q)
                low_q <= rxd_rise;
            phase_q <= ~phase_q;
        end
    end

    // Byte is presented in the same cycle its last nibble is sampled.
    always_comb begin
        byte_data  = mode_1g ? {rxd_fall, rxd_rise} : {rxd_rise, low_q};
        byte_valid = en && (mode_1g || phase_q);
        odd_nibble = phase_q;
    end

endmodule

// File: rtl/rgmii_rx_frame.sv
// RGMII receive frame stage: preamble/SFD strip, byte stream with markers,
// length/error checks and saturating statistics. Optional in-band link status
// decode is enabled with RGMII_RX_INBAND_STATUS_EN.
//
// state    | meaning
// IDLE     | no carrier; watches for dv, false carrier and in-band status
// PREAMBLE | consuming 0x55 / nibble 5 until the SFD
// DATA     | payload; one byte held back so the last one can carry m_eop
// DROP     | bad preamble, discard until dv drops
module rgmii_rx_frame
    import rgmii_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 14,
    parameter int CNT_W   = 16
) (
    input  logic             mac_rxc,
    input  logic             rst_n,
    input  logic             speed_1g,
    input  logic             ctl_rise,
    input  logic             ctl_fall,
    input  logic [3:0]       rxd_rise,
    input  logic [3:0]       rxd_fall,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_err,
    output logic [LEN_W-1:0] frame_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_duplex
);

    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

    rx_state_e        state;
    logic             mode_1g;
    logic             dv;
    logic             er;
    logic [7:0]       hold_q;
    logic             hold_vld;
    logic             first_q;
    logic             er_seen;
    logic             fc_active;
    logic [LEN_W-1:0] len_q;

    logic [7:0]       asm_byte;
    logic             asm_valid;
    logic             asm_odd;
    logic             asm_en;
    logic             asm_clr;

    logic             pre_is_pre;
    logic             pre_is_sfd;
    logic             eop_now;
    logic             eop_bad;
    logic             zero_frame;
    logic             drop_entry;
    logic             fc_event;
    logic             frame_inc;
    logic             err_inc;

    always_comb begin
        dv         = ctl_rise;
        er         = ctl_rise ^ ctl_fall;
        asm_en     = (state == ST_DATA) && dv;
        asm_clr    = (state != ST_DATA);
        pre_is_pre = mode_1g ? ({rxd_fall, rxd_rise} == PREAMBLE_BYTE)
                             : (rxd_rise == PREAMBLE_NIBBLE);
        pre_is_sfd = mode_1g ? ({rxd_fall, rxd_rise} == SFD_BYTE)
                             : (rxd_rise == SFD_NIBBLE);
        eop_now    = (state == ST_DATA) && !dv && hold_vld;
        eop_bad    = er_seen || (len_q == LEN_SAT) || asm_odd;
        zero_frame = (state == ST_DATA) && !dv && !hold_vld;
        drop_entry = (state == ST_PREAMBLE) && dv && !pre_is_pre && !pre_is_sfd;
        fc_event   = (state == ST_IDLE) && !dv && er &&
                     (rxd_rise == FALSE_CARRIER) && !fc_active;
        frame_inc  = eop_now && !eop_bad;
        err_inc    = (eop_now && eop_bad) || zero_frame || drop_entry || fc_event;
    end

    rgmii_rx_nibble_asm u_asm (
        .mac_rxc    (mac_rxc),
        .rst_n      (rst_n),
        .mode_1g    (mode_1g),
        .en         (asm_en),
        .clr        (asm_clr),
        .rxd_rise   (rxd_rise),
        .rxd_fall   (rxd_fall),
        .byte_data  (asm_byte),
        .byte_valid (asm_valid),
        .odd_nibble (asm_odd)
    );

    always_ff @(posedge mac_rxc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_1g   <= 1'b0;
            hold_q    <= 8'h00;
            hold_vld  <= 1'b0;
            first_q   <= 1'b0;
            er_seen   <= 1'b0;
            fc_active <= 1'b0;
            len_q     <= '0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_sop     <= 1'b0;
            m_eop     <= 1'b0;
            m_err     <= 1'b0;
            frame_len <= '0;
        end else begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_err   <= 1'b0;

            // A false-carrier event counts once and lasts until er drops.
            if (!er)
                fc_active <= 1'b0;
            else if (fc_event)
                fc_active <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (dv) begin
                        state   <= ST_PREAMBLE;
                        mode_1g <= speed_1g;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv) begin
                        state <= ST_IDLE;
                    end else if (pre_is_sfd) begin
                        state    <= ST_DATA;
                        first_q  <= 1'b1;
                        hold_vld <= 1'b0;
                        er_seen  <= 1'b0;
                        len_q    <= '0;
                    end else if (!pre_is_pre) begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (dv) begin
                        if (er)
                            er_seen <= 1'b1;
                        if (asm_valid) begin
                            if (hold_vld) begin
                                m_valid <= 1'b1;
                                m_data  <= hold_q;
                                m_sop   <= first_q;
                                first_q <= 1'b0;
                            end
                            hold_q   <= asm_byte;
                            hold_vld <= 1'b1;
                            if (len_q != LEN_SAT)
                                len_q <= len_q + 1'b1;
                        end
                    end else begin
                        if (hold_vld) begin
                            m_valid   <= 1'b1;
                            m_data    <= hold_q;
                            m_sop     <= first_q;
                            m_eop     <= 1'b1;
                            m_err     <= eop_bad;
                            frame_len <= len_q;
                        end
                        hold_vld <= 1'b0;
                        first_q  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!dv)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge mac_rxc or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_inc && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 1'b1;
            if (err_inc && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef RGMII_RX_INBAND_STATUS_EN
    // Status nibble is repeated on both edges during inter-frame gaps.
    always_ff @(posedge mac_rxc or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= 1'b0;
            link_speed  <= SPEED_10;
            link_duplex <= 1'b0;
        end else if ((state == ST_IDLE) && !dv && !er && (rxd_rise == rxd_fall)) begin
            link_up     <= rxd_rise[IB_LINK_BIT];
            link_speed  <= inband_speed(rxd_rise);
            link_duplex <= rxd_rise[IB_DUPLEX_BIT];
        end
    end
`else
    assign link_up     = 1'b0;
    assign link_speed  = SPEED_10;
    assign link_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Directed bench for rgmii_rx_frame; in-band checks follow RGMII_RX_INBAND_STATUS_EN.
module tb_rgmii_rx_frame;

    localparam int MAX_LEN = 1518;
    localparam int LEN_W   = 14;
    localparam int CNT_W   = 16;

    logic             mac_rxc  = 1'b0;
    logic             rst_n    = 1'b0;
    logic             speed_1g = 1'b1;
    logic             ctl_rise = 1'b0;
    logic             ctl_fall = 1'b0;
    logic [3:0]       rxd_rise = 4'h0;
    logic [3:0]       rxd_fall = 4'h0;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_sop;
    logic             m_eop;
    logic             m_err;
    logic [LEN_W-1:0] frame_len;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             link_up;
    logic [1:0]       link_speed;
    logic             link_duplex;

    int n_assert  = 0;
    int n_fail    = 0;
    int exp_frame = 0;
    int exp_err   = 0;

    logic [7:0]       beats[$];
    int               sop_cnt = 0;
    int               eop_cnt = 0;
    int               sop_idx = -1;
    int               eop_idx = -1;
    logic [LEN_W-1:0] last_len = '0;
    logic             last_err = 1'b0;

    rgmii_rx_frame #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .mac_rxc     (mac_rxc),
        .rst_n       (rst_n),
        .speed_1g    (speed_1g),
        .ctl_rise    (ctl_rise),
        .ctl_fall    (ctl_fall),
        .rxd_rise    (rxd_rise),
        .rxd_fall    (rxd_fall),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_sop       (m_sop),
        .m_eop       (m_eop),
        .m_err       (m_err),
        .frame_len   (frame_len),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .link_duplex (link_duplex)
    );

    always #5 mac_rxc = ~mac_rxc;

    always @(posedge mac_rxc) begin
        #1;
        if (m_valid) begin
            beats.push_back(m_data);
            if (m_sop) begin
                sop_cnt++;
                sop_idx = beats.size() - 1;
            end
            if (m_eop) begin
                eop_cnt++;
                eop_idx  = beats.size() - 1;
                last_len = frame_len;
                last_err = m_err;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic dv, input logic er, input logic [3:0] r, input logic [3:0] f);
        @(negedge mac_rxc);
        ctl_rise = dv;
        ctl_fall = dv ^ er;
        rxd_rise = r;
        rxd_fall = f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic clr_mon();
        beats.delete();
        sop_cnt  = 0;
        eop_cnt  = 0;
        sop_idx  = -1;
        eop_idx  = -1;
        last_len = '0;
        last_err = 1'b0;
    endtask

    task automatic byte_1g(input logic [7:0] b, input logic er);
        drv(1'b1, er, b[3:0], b[7:4]);
    endtask

    // Payload byte i is (i+1) mod 256; er_idx < 0 means no error pulse.
    task automatic frame_1g(input int n, input int er_idx, input int gap);
        for (int i = 0; i < 7; i++) byte_1g(8'h55, 1'b0);
        byte_1g(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) byte_1g(8'((i + 1) % 256), 1'(i == er_idx));
        idle(gap);
    endtask

    task automatic frame_100(input int n, input logic extra, input int gap);
        logic [7:0] b;
        for (int i = 0; i < 15; i++) drv(1'b1, 1'b0, 4'h5, 4'h5);
        drv(1'b1, 1'b0, 4'hD, 4'hD);
        for (int i = 0; i < n; i++) begin
            b = 8'((i + 1) % 256);
            drv(1'b1, 1'b0, b[3:0], b[3:0]);
            drv(1'b1, 1'b0, b[7:4], b[7:4]);
        end
        if (extra) drv(1'b1, 1'b0, 4'h3, 4'h3);
        idle(gap);
    endtask

    task automatic check_data(input int n, input int frames);
        int bad;
        bad = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== 8'((i % n) + 1)) bad++;
        chk("beat_count", beats.size(), n * frames);
        chk("data_mismatches", bad, 0);
    endtask

    task automatic check_counters();
        chk("frame_cnt", frame_cnt, exp_frame);
        chk("err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        repeat (3) @(negedge mac_rxc);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_sop", m_sop, 0);
        chk("rst_m_eop", m_eop, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_link_speed", link_speed, 0);
        check_counters();
        @(negedge mac_rxc);
        rst_n = 1'b1;
        idle(3);

        // 1000 mode, 64-byte good frame
        speed_1g = 1'b1;
        clr_mon();
        frame_1g(64, -1, 4);
        check_data(64, 1);
        chk("g64_sop_cnt", sop_cnt, 1);
        chk("g64_sop_idx", sop_idx, 0);
        chk("g64_eop_cnt", eop_cnt, 1);
        chk("g64_eop_idx", eop_idx, 63);
        chk("g64_len", last_len, 64);
        chk("g64_err", last_err, 0);
        exp_frame = 1;
        check_counters();

        // 10/100 mode, same frame as nibbles
        speed_1g = 1'b0;
        clr_mon();
        frame_100(64, 1'b0, 4);
        check_data(64, 1);
        chk("n64_eop_cnt", eop_cnt, 1);
        chk("n64_len", last_len, 64);
        chk("n64_err", last_err, 0);
        exp_frame = 2;
        check_counters();

        // 10/100 frame ending on a dangling nibble
        clr_mon();
        frame_100(5, 1'b1, 4);
        check_data(5, 1);
        chk("odd_eop_cnt", eop_cnt, 1);
        chk("odd_len", last_len, 5);
        chk("odd_err", last_err, 1);
        exp_err = 1;
        check_counters();

        // er pulse mid-payload
        speed_1g = 1'b1;
        clr_mon();
        frame_1g(20, 10, 4);
        check_data(20, 1);
        chk("er_err", last_err, 1);
        chk("er_len", last_len, 20);
        exp_err = 2;
        check_counters();

        // exactly MAX_LEN is good
        clr_mon();
        frame_1g(MAX_LEN, -1, 4);
        check_data(MAX_LEN, 1);
        chk("max_err", last_err, 0);
        chk("max_len", last_len, MAX_LEN);
        exp_frame = 3;
        check_counters();

        // MAX_LEN+2 bytes: streams all, length saturates at MAX_LEN+1
        clr_mon();
        frame_1g(MAX_LEN + 2, -1, 4);
        check_data(MAX_LEN + 2, 1);
        chk("long_err", last_err, 1);
        chk("long_len", last_len, MAX_LEN + 1);
        exp_err = 3;
        check_counters();

        // corrupted preamble byte 0x57
        clr_mon();
        for (int i = 0; i < 3; i++) byte_1g(8'h55, 1'b0);
        byte_1g(8'h57, 1'b0);
        for (int i = 0; i < 3; i++) byte_1g(8'h55, 1'b0);
        byte_1g(8'hD5, 1'b0);
        for (int i = 0; i < 8; i++) byte_1g(8'(i + 1), 1'b0);
        idle(4);
        chk("drop_beats", beats.size(), 0);
        exp_err = 4;
        check_counters();

        // false carrier lasting three cycles counts once
        clr_mon();
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 4'hE, 4'hE);
        idle(4);
        chk("fc_beats", beats.size(), 0);
        exp_err = 5;
        check_counters();

        // zero-byte frame
        clr_mon();
        frame_1g(0, -1, 4);
        chk("zero_beats", beats.size(), 0);
        exp_err = 6;
        check_counters();

        // single-byte frame carries both markers
        clr_mon();
        frame_1g(1, -1, 4);
        check_data(1, 1);
        chk("one_sop_idx", sop_idx, 0);
        chk("one_eop_idx", eop_idx, 0);
        chk("one_len", last_len, 1);
        exp_frame = 4;
        check_counters();

        // back-to-back frames with one idle cycle
        clr_mon();
        frame_1g(12, -1, 1);
        frame_1g(12, -1, 4);
        check_data(12, 2);
        chk("b2b_sop_cnt", sop_cnt, 2);
        chk("b2b_eop_cnt", eop_cnt, 2);
        chk("b2b_sop2_idx", sop_idx, 12);
        exp_frame = 6;
        check_counters();

        // reset mid-payload
        clr_mon();
        for (int i = 0; i < 7; i++) byte_1g(8'h55, 1'b0);
        byte_1g(8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) byte_1g(8'(i + 1), 1'b0);
        @(negedge mac_rxc);
        rst_n    = 1'b0;
        ctl_rise = 1'b0;
        ctl_fall = 1'b0;
        #1;
        chk("rstmid_m_valid", m_valid, 0);
        exp_frame = 0;
        exp_err   = 0;
        check_counters();
        repeat (2) @(negedge mac_rxc);
        rst_n = 1'b1;
        idle(4);
        chk("rstmid_eop_cnt", eop_cnt, 0);
        clr_mon();
        frame_1g(16, -1, 4);
        check_data(16, 1);
        chk("after_rst_len", last_len, 16);
        chk("after_rst_err", last_err, 0);
        exp_frame = 1;
        check_counters();

        // in-band status nibble 4'b1101 on both edges
        drv(1'b0, 1'b0, 4'b1101, 4'b1101);
        drv(1'b0, 1'b0, 4'b1101, 4'b1101);
        @(negedge mac_rxc);
        #1;
`ifdef RGMII_RX_INBAND_STATUS_EN
        chk("link_up", link_up, 1);
        chk("link_speed", link_speed, 2'b10);
        chk("link_duplex", link_duplex, 1);
`else
        chk("link_up", link_up, 0);
        chk("link_speed", link_speed, 2'b00);
        chk("link_duplex", link_duplex, 0);
`endif
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
